// File: rtl/basic_computer_pkg.sv
// Shared encodings for the basic computer control unit:
// FSM states, opcodes, select/function codes and the control bundle.
package basic_computer_pkg;

    typedef enum logic [1:0] {
        FETCH_L = 2'd0,
        FETCH_H = 2'd1,
        EXEC    = 2'd2,
        HALT    = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_BRA  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_HLT  = 4'd7;
    localparam logic [3:0] OP_LDAR = 4'd8;

    localparam logic [3:0] RF_NONE  = 4'b1111;
    localparam logic [2:0] ARF_PC   = 3'b011;
    localparam logic [2:0] ARF_AR   = 3'b101;
    localparam logic [2:0] ARF_NONE = 3'b111;

    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_INC  = 3'b001;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD16  = 5'b10100;

    localparam logic [1:0] OUTD_PC = 2'b00;
    localparam logic [1:0] OUTD_AR = 2'b10;

    localparam logic [1:0] MUXA_ALU = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd2;
    localparam logic [1:0] MUXA_IMM = 2'd3;
    localparam logic [1:0] MUXB_IMM = 2'd3;
    localparam logic       MUXC_ALU = 1'b0;

    typedef struct packed {
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        rf_outa:  3'd0,
        rf_outb:  3'd0,
        rf_fun:   3'd0,
        rf_reg:   RF_NONE,
        alu_fun:  5'd0,
        alu_wf:   1'b0,
        arf_outc: 2'd0,
        arf_outd: 2'd0,
        arf_fun:  3'd0,
        arf_reg:  ARF_NONE,
        ir_lh:    1'b0,
        ir_write: 1'b0,
        mem_wr:   1'b0,
        mem_cs:   1'b1,
        mux_a:    2'd0,
        mux_b:    2'd0,
        mux_c:    1'b0
    };

    // Active-low one-cold write enable for R1..R4 from a 2-bit index.
    function automatic logic [3:0] rf_sel(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/basic_computer_sequencer_instruction_decoder.sv
// EXEC-cycle decode: opcode, register fields and the Z flag
// map to one full datapath control vector.
module instruction_decoder
    import basic_computer_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] rx,
    input  logic [1:0] ry,
    input  logic       flag_z,
    output ctrl_t      ctrl
);

    // Start from idle and override only the fields each opcode uses.
    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (opcode)
            OP_NOP: begin
            end
            OP_LDI: begin
                ctrl.mux_a  = MUXA_IMM;
                ctrl.rf_fun = FUN_LOAD;
                ctrl.rf_reg = rf_sel(rx);
            end
            OP_LD: begin
                ctrl.arf_outd = OUTD_AR;
                ctrl.mem_cs   = 1'b0;
                ctrl.mux_a    = MUXA_MEM;
                ctrl.rf_fun   = FUN_LOAD;
                ctrl.rf_reg   = rf_sel(rx);
            end
            OP_ST: begin
                ctrl.rf_outa  = {1'b0, rx};
                ctrl.alu_fun  = ALU_PASS_A;
                ctrl.mux_c    = MUXC_ALU;
                ctrl.arf_outd = OUTD_AR;
                ctrl.mem_cs   = 1'b0;
                ctrl.mem_wr   = 1'b1;
            end
            OP_ADD: begin
                ctrl.rf_outa = {1'b0, rx};
                ctrl.rf_outb = {1'b0, ry};
                ctrl.alu_fun = ALU_ADD16;
                ctrl.alu_wf  = 1'b1;
                ctrl.mux_a   = MUXA_ALU;
                ctrl.rf_fun  = FUN_LOAD;
                ctrl.rf_reg  = rf_sel(rx);
            end
            OP_BRA: begin
                ctrl.mux_b   = MUXB_IMM;
                ctrl.arf_fun = FUN_LOAD;
                ctrl.arf_reg = ARF_PC;
            end
            OP_BNE: begin
                if (!flag_z) begin
                    ctrl.mux_b   = MUXB_IMM;
                    ctrl.arf_fun = FUN_LOAD;
                    ctrl.arf_reg = ARF_PC;
                end
            end
            OP_HLT: begin
            end
            OP_LDAR: begin
                ctrl.mux_b   = MUXB_IMM;
                ctrl.arf_fun = FUN_LOAD;
                ctrl.arf_reg = ARF_AR;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/basic_computer_sequencer.sv
// Hardwired fetch/execute sequencer for the basic computer datapath.
// Two byte fetches into IR, one decode/execute cycle, sticky HALT.
module basic_computer_sequencer
    import basic_computer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [1:0]  State
);

    state_e state_q;
    state_e state_d;
    ctrl_t  exec_ctrl;
    ctrl_t  ctrl;
    logic   unused_inputs;

    assign unused_inputs = ^{IROut[7:0], ALU_Flags[2:0]};

    instruction_decoder u_dec (
        .opcode (IROut[15:12]),
        .rx     (IROut[11:10]),
        .ry     (IROut[9:8]),
        .flag_z (ALU_Flags[3]),
        .ctrl   (exec_ctrl)
    );

    // State register; reset returns to the first fetch cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= FETCH_L;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fixed three-cycle loop, HLT parks in HALT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = EXEC;
            EXEC: begin
                if (IROut[15:12] == OP_HLT) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH_L;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH_L;
        endcase
    end

    // Control vector; reset forces idle without waiting for a clock.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (Reset) begin
            unique case (state_q)
                FETCH_L, FETCH_H: begin
                    ctrl.arf_outd = OUTD_PC;
                    ctrl.mem_cs   = 1'b0;
                    ctrl.ir_write = 1'b1;
                    ctrl.ir_lh    = (state_q == FETCH_H);
                    ctrl.arf_reg  = ARF_PC;
                    ctrl.arf_fun  = FUN_INC;
                end
                EXEC:    ctrl = exec_ctrl;
                HALT:    ctrl = CTRL_IDLE;
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign RF_OutASel  = ctrl.rf_outa;
    assign RF_OutBSel  = ctrl.rf_outb;
    assign RF_FunSel   = ctrl.rf_fun;
    assign RF_RegSel   = ctrl.rf_reg;
    assign RF_ScrSel   = 4'b1111;
    assign ALU_FunSel  = ctrl.alu_fun;
    assign ALU_WF      = ctrl.alu_wf;
    assign ARF_OutCSel = ctrl.arf_outc;
    assign ARF_OutDSel = ctrl.arf_outd;
    assign ARF_FunSel  = ctrl.arf_fun;
    assign ARF_RegSel  = ctrl.arf_reg;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Write    = ctrl.ir_write;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a;
    assign MuxBSel     = ctrl.mux_b;
    assign MuxCSel     = ctrl.mux_c;
    assign Halted      = (state_q == HALT);
    assign State       = state_q;

endmodule

// File: tb/tb_basic_computer_sequencer.sv
// Scoreboard bench for basic_computer_sequencer: directed
// instructions push expected vectors, a negedge monitor compares.
module tb_basic_computer_sequencer;

    typedef struct packed {
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
        logic [1:0] state;
    } obs_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;
    logic [1:0]  State;

    obs_t  act;
    obs_t  exp_q[$];
    string name_q[$];
    obs_t  mon_e;
    string mon_n;
    int    checks = 0;
    int    fails = 0;

    basic_computer_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .ALU_Flags   (ALU_Flags),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RegSel   (RF_RegSel),
        .RF_ScrSel   (RF_ScrSel),
        .ALU_FunSel  (ALU_FunSel),
        .ALU_WF      (ALU_WF),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .Halted      (Halted),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel,
               RF_ScrSel, ALU_FunSel, ALU_WF, ARF_OutCSel,
               ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH,
               IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
               MuxCSel, Halted, State};
    end

    // Monitor: one expected vector consumed per falling edge.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                fails++;
                $display("FAIL %s: got %h expected %h",
                         mon_n, act, mon_e);
            end
        end
    end

    function automatic obs_t idle(input logic [1:0] st);
        obs_t o;
        o = '0;
        o.rf_reg = 4'b1111;
        o.rf_scr = 4'b1111;
        o.arf_reg = 3'b111;
        o.mem_cs = 1'b1;
        o.state = st;
        o.halted = (st == 2'd3);
        return o;
    endfunction

    function automatic obs_t fetch(input logic hi);
        obs_t o;
        o = idle({1'b0, hi});
        o.arf_outd = 2'b00;
        o.mem_cs = 1'b0;
        o.ir_write = 1'b1;
        o.ir_lh = hi;
        o.arf_reg = 3'b011;
        o.arf_fun = 3'b001;
        return o;
    endfunction

    task automatic push(input string n, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic run(input string n, input logic [15:0] ir,
                       input logic [3:0] fl, input obs_t ex);
        push({n, "_fl"}, fetch(1'b0));
        step();
        push({n, "_fh"}, fetch(1'b1));
        step();
        IROut = ir;
        ALU_Flags = fl;
        push(n, ex);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t x;
        Reset = 1'b0;
        IROut = 16'h0000;
        ALU_Flags = 4'h0;
        step();
        push("rst_idle", idle(2'd0));
        step();
        Reset = 1'b1;

        push("fl_a", fetch(1'b0));
        step();
        push("fh_a", fetch(1'b1));
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        push("rst_mid", idle(2'd0));
        step();
        step();
        Reset = 1'b1;

        x = idle(2'd2);
        x.mux_a = 2'd3;
        x.rf_reg = 4'b1101;
        x.rf_fun = 3'b010;
        run("ldi", 16'h1A55, 4'h0, x);

        x = idle(2'd2);
        x.rf_outa = 3'd0;
        x.rf_outb = 3'd1;
        x.alu_fun = 5'b10100;
        x.alu_wf = 1'b1;
        x.mux_a = 2'd0;
        x.rf_reg = 4'b0111;
        x.rf_fun = 3'b010;
        run("add", 16'h4100, 4'h0, x);

        x = idle(2'd2);
        x.arf_outd = 2'b10;
        x.mem_cs = 1'b0;
        x.mux_a = 2'd2;
        x.rf_reg = 4'b1110;
        x.rf_fun = 3'b010;
        run("ld", 16'h2C00, 4'h0, x);

        x = idle(2'd2);
        x.rf_outa = 3'd1;
        x.alu_fun = 5'b10000;
        x.mux_c = 1'b0;
        x.arf_outd = 2'b10;
        x.mem_cs = 1'b0;
        x.mem_wr = 1'b1;
        run("st", 16'h3400, 4'h0, x);

        x = idle(2'd2);
        x.mux_b = 2'd3;
        x.arf_reg = 3'b011;
        x.arf_fun = 3'b010;
        run("bne_z0", 16'h6020, 4'b0111, x);
        run("bra", 16'h5000, 4'b1000, x);

        run("bne_z1", 16'h6020, 4'b1000, idle(2'd2));

        x = idle(2'd2);
        x.mux_b = 2'd3;
        x.arf_reg = 3'b101;
        x.arf_fun = 3'b010;
        run("ldar", 16'h8000, 4'h0, x);

        run("nop", 16'h0FFF, 4'h0, idle(2'd2));
        run("op_f", 16'hF123, 4'hF, idle(2'd2));

        run("hlt", 16'h7000, 4'h0, idle(2'd2));
        IROut = 16'h1A55;
        for (int i = 0; i < 12; i++) begin
            push("halt", idle(2'd3));
            step();
        end

        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/basic_computer_sequencer.md
# basic_computer_sequencer

Hardwired control unit for the 16-bit basic computer datapath (RF, ARF, IR, ALU, Memory, MUX A/B/C). It fetches each 16-bit instruction as two byte reads into IR, decodes a 9-opcode subset, and drives every datapath select/enable for one execute cycle. It sits beside the datapath: it reads `IROut` and `ALU_Flags`, and its outputs connect one-to-one to the datapath's control inputs.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `Clock` in 1: single system clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low.
- `IROut` in 16: instruction register contents.
- `ALU_Flags` in 4: {Z,C,N,O}, registered in the ALU.
- `RF_OutASel`, `RF_OutBSel` out 3: RF read port selects.
- `RF_FunSel` out 3: RF function.
- `RF_RegSel` out 4: RF write enables.
- `RF_ScrSel` out 4: scratch-register write enables; constant 4'b1111.
- `ALU_FunSel` out 5: ALU function.
- `ALU_WF` out 1: ALU flag write.
- `ARF_OutCSel`, `ARF_OutDSel` out 2: ARF read port selects.
- `ARF_FunSel` out 3: ARF function.
- `ARF_RegSel` out 3: ARF write enables.
- `IR_LH` out 1: IR half select; 0 = low byte.
- `IR_Write` out 1: IR load enable.
- `Mem_WR` out 1: 1 = write.
- `Mem_CS` out 1: active-low chip select.
- `MuxASel`, `MuxBSel` out 2; `MuxCSel` out 1: datapath mux selects.
- `Halted` out 1: core stopped.
- `State` out 2: current state, for debug.

## Operation
- States: FETCH_L=0, FETCH_H=1, EXEC=2, HALT=3. Reset puts the FSM in FETCH_L.
- Sequence: FETCH_L→FETCH_H→EXEC→FETCH_L. The HLT opcode moves EXEC→HALT. HALT is left only by reset.
- Encodings (decided):
  - RegSel is active-low: RF R1..R4 = 0111/1011/1101/1110; ARF PC/AR/SP = 011/101/110; all ones = no write.
  - FunSel: LOAD = 3'b010, INC = 3'b001.
  - ALU: PASS_A = 5'b10000, ADD16 = 5'b10100.
  - OutD select: PC = 2'b00, AR = 2'b10.
- Idle vector: RegSels all ones; IR_Write, Mem_WR, ALU_WF = 0; Mem_CS = 1; all other outputs 0.
  - Idle is driven whenever `Reset`=0, in HALT, and for all fields not listed below.
- FETCH_L:
  - ARF_OutDSel=PC, Mem_CS=0, IR_Write=1, IR_LH=0.
  - ARF_RegSel=PC, ARF_FunSel=INC.
- FETCH_H: same as FETCH_L with IR_LH=1.
- EXEC instruction fields: opcode = IROut[15:12]; Rx = IROut[11:10]; Ry = IROut[9:8]; imm = IROut[7:0]. Register index 0..3 maps to R1..R4.
  - 0 NOP: idle.
  - 1 LDI: MuxASel=3, RF load Rx.
  - 2 LD: OutD=AR, Mem_CS=0, MuxASel=2, RF load Rx.
  - 3 ST: OutA=Rx, ALU PASS_A, MuxCSel=0, OutD=AR, Mem_CS=0, Mem_WR=1.
  - 4 ADD: OutA=Rx, OutB=Ry, ALU ADD16, ALU_WF=1, MuxASel=0, RF load Rx.
  - 5 BRA: MuxBSel=3, ARF load PC.
  - 6 BNE: as BRA only if Z=0; otherwise idle.
  - 7 HLT: idle, then go to HALT.
  - 8 LDAR: MuxBSel=3, ARF load AR.
  - 9–15: treated as NOP.
- `Halted` = (state==HALT).

## Timing
- Outputs are combinational from the registered state and `IROut` (Moore plus decode). No output registers.
- Instruction latency is 3 cycles. IR is complete at the start of EXEC.
- BNE samples flags written by any earlier ADD's EXEC edge.
- An ADD immediately before BNE is visible to BNE, because fetch inserts 2 cycles between them.
- PC increments twice per instruction. A branch's load in EXEC overrides those increments, which have already completed.
- Reset mid-instruction:
  - State returns to FETCH_L immediately.
  - Outputs go idle asynchronously.
  - No partial write completes.
- PC wrap-around is handled by the ARF (0xFFFF+1 = 0x0000); the controller does not check it.

## Structure
- Package `basic_computer_pkg` holds:
  - the state enum;
  - opcode constants;
  - RF/ARF RegSel, FunSel and OutSel codes;
  - ALU function codes;
  - the idle control vector.
- One sub-module is natural: `instruction_decoder` (combinational, opcode+fields+Z → EXEC control vector). The FSM and output mux stay in the top.

## Test plan
- Reset low mid-FETCH_H → outputs idle immediately. After release: FETCH_L with Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=011, ARF_FunSel=001.
- Fetch cycles: `State` goes 0,1,2,0. IR_LH is 0 then 1. PC INC is asserted in both fetch cycles.
- IROut=0x1A55 (LDI R3,0x55) in EXEC → MuxASel=3, RF_RegSel=1101, RF_FunSel=010.
- IROut=0x4100 (ADD R1,R2) → RF_OutASel=0, RF_OutBSel=1, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0111.
- IROut=0x6020 (BNE 0x20):
  - Z=0 → MuxBSel=3, ARF_RegSel=011, ARF_FunSel=010.
  - Z=1 → idle vector.
- IROut=0x7000 → HALT next cycle, Halted=1, idle held for ≥10 cycles. Opcode 0xF behaves as NOP.
